// File: rtl/hazard_control_unit.sv
// Purpose : pipeline hazard control (load-use stall, mispredict flush) plus drain-and-halt sequencing.
// Latency : hazard outputs are combinational (0 cycles); halt drains DRAIN_CYCLES cycles after the halt_req edge.
// Backpr. : stall freezes PC and IF/ID; bubbles are inserted through flush_id_ie; no upstream handshake.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   id_rs, id_rt        source fields of the instruction in ID; id_uses_rt marks rt as a real source
//   ie_rt, ie_mem_read  destination and load flag of the instruction in EX (ID/IE latch outputs)
//   ex_branch, ex_taken, ex_prediction   branch resolution in EX and the prediction carried with it
//   halt_req            start a drain; the pipeline then stays halted until reset
//   stall, flush_if_id, flush_id_ie, pc_redirect, halted   pipeline control outputs
//   stall_count, flush_count   saturating event counters, present only when HAZARD_STATS_EN is defined
//
// Build option: define HAZARD_STATS_EN to add the statistics counters and their ports.
// DRAIN_CYCLES must lie in 1..15 (the drain counter is 4 bits wide).

module hazard_control_unit #(
    parameter int DRAIN_CYCLES = 4,
    parameter int STAT_WIDTH   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic [4:0] ie_rt,
    input  logic       ie_mem_read,
    input  logic       ex_branch,
    input  logic       ex_taken,
    input  logic       ex_prediction,
    input  logic       halt_req,
    output logic       stall,
    output logic       flush_if_id,
    output logic       flush_id_ie,
    output logic       pc_redirect,
    output logic       halted
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stall_count,
    output logic [STAT_WIDTH-1:0] flush_count
`endif
);

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_DRAIN  = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    // The counter runs DRAIN_CYCLES-1 down to 0, one DRAIN cycle per value.
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] drain_cnt;
    logic [3:0] drain_cnt_nxt;

    logic load_use;
    logic mispredict;

    // r0 is hard-wired zero, so a load "into" r0 never creates a dependency.
    always_comb begin
        load_use   = ie_mem_read && (ie_rt != 5'd0) &&
                     ((ie_rt == id_rs) || (id_uses_rt && (ie_rt == id_rt)));
        mispredict = ex_branch && (ex_taken != ex_prediction);
    end

    always_comb begin
        stall         = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ie   = 1'b0;
        pc_redirect   = 1'b0;
        halted        = 1'b0;
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;

        case (state)
            ST_RUN: begin
                // A mispredict squashes the dependent instruction in ID anyway,
                // so it wins over the load-use stall.
                if (mispredict) begin
                    flush_if_id = 1'b1;
                    flush_id_ie = 1'b1;
                    pc_redirect = 1'b1;
                end else if (load_use) begin
                    stall       = 1'b1;
                    flush_id_ie = 1'b1;
                end
                if (halt_req) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end
            end

            ST_DRAIN: begin
                // Fetch is frozen and bubbles push the in-flight work out.
                // A branch already in EX may still redirect; the drain count keeps running.
                stall       = 1'b1;
                flush_id_ie = 1'b1;
                if (mispredict) begin
                    flush_if_id = 1'b1;
                    pc_redirect = 1'b1;
                end
                if (drain_cnt == 4'd0) begin
                    state_nxt = ST_HALTED;
                end else begin
                    drain_cnt_nxt = drain_cnt - 4'd1;
                end
            end

            ST_HALTED: begin
                // Terminal until reset; halt_req and branches have no effect.
                stall       = 1'b1;
                flush_id_ie = 1'b1;
                halted      = 1'b1;
            end

            default: begin
                // Unused encoding: fall back to RUN.
                state_nxt     = ST_RUN;
                drain_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            drain_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

`ifdef HAZARD_STATS_EN
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != STAT_MAX)) begin
                stall_count <= stall_count + STAT_ONE;
            end
            if (flush_if_id && (flush_count != STAT_MAX)) begin
                flush_count <= flush_count + STAT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Purpose : self-checking bench for hazard_control_unit against a cycle-level behavioural model.
// Latency : inputs driven at the falling edge, outputs sampled 1 time unit later.
// Backpr. : none; every sequence runs a fixed number of cycles.

module tb_hazard_control_unit;

    localparam int DRAIN = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ie_rt;
    logic       id_uses_rt, ie_mem_read;
    logic       ex_branch, ex_taken, ex_prediction, halt_req;
    logic       stall, flush_if_id, flush_id_ie, pc_redirect, halted;
    logic [4:0] obs;

    always #5 clk = ~clk;

    assign obs = {stall, flush_if_id, flush_id_ie, pc_redirect, halted};

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count, flush_count;
    logic [1:0]  n_stall_count, n_flush_count;
    logic        n_stall, n_flush_if_id, n_flush_id_ie, n_pc_redirect, n_halted;
    logic [4:0]  n_obs;
    assign n_obs = {n_stall, n_flush_if_id, n_flush_id_ie, n_pc_redirect, n_halted};
`endif

    hazard_control_unit #(.DRAIN_CYCLES(DRAIN), .STAT_WIDTH(32)) u_dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ie_rt(ie_rt), .ie_mem_read(ie_mem_read),
        .ex_branch(ex_branch), .ex_taken(ex_taken), .ex_prediction(ex_prediction),
        .halt_req(halt_req),
        .stall(stall), .flush_if_id(flush_if_id), .flush_id_ie(flush_id_ie),
        .pc_redirect(pc_redirect), .halted(halted)
`ifdef HAZARD_STATS_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

`ifdef HAZARD_STATS_EN
    hazard_control_unit #(.DRAIN_CYCLES(DRAIN), .STAT_WIDTH(2)) u_dut_narrow (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ie_rt(ie_rt), .ie_mem_read(ie_mem_read),
        .ex_branch(ex_branch), .ex_taken(ex_taken), .ex_prediction(ex_prediction),
        .halt_req(halt_req),
        .stall(n_stall), .flush_if_id(n_flush_if_id), .flush_id_ie(n_flush_id_ie),
        .pc_redirect(n_pc_redirect), .halted(n_halted),
        .stall_count(n_stall_count), .flush_count(n_flush_count)
    );
`endif

    int checks = 0;
    int passes = 0;

    // Reference model: "halting" plus the number of edges since the halt was taken.
    bit     m_halting = 1'b0;
    int     m_elapsed = 0;
    longint m_stall_tot = 0;
    longint m_flush_tot = 0;

    // Expected {stall, flush_if_id, flush_id_ie, pc_redirect, halted} for the current cycle.
    function automatic logic [4:0] model_out();
        bit lu;
        bit mp;
        lu = ie_mem_read && (ie_rt != 0) && ((ie_rt == id_rs) || (id_uses_rt && (ie_rt == id_rt)));
        mp = ex_branch && (ex_taken != ex_prediction);
        if (m_halting && m_elapsed >= DRAIN) return 5'b10101;
        if (m_halting)                       return {1'b1, mp, 1'b1, mp, 1'b0};
        if (mp)                              return 5'b01110;
        if (lu)                              return 5'b10100;
        return 5'b00000;
    endfunction

    task automatic set_in(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                          input logic [4:0] iert, input logic mr, input logic br, input logic tk,
                          input logic pr, input logic hr);
        reset = r; id_rs = rs; id_rt = rt; id_uses_rt = uses; ie_rt = iert; ie_mem_read = mr;
        ex_branch = br; ex_taken = tk; ex_prediction = pr; halt_req = hr;
    endtask

    task automatic clear_in();
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one clock and move the model across the same edge.
    task automatic tick();
        logic [4:0] e;
        e = model_out();
        @(posedge clk);
        if (reset) begin
            m_halting = 1'b0; m_elapsed = 0; m_stall_tot = 0; m_flush_tot = 0;
        end else begin
            m_stall_tot += e[4];
            m_flush_tot += e[3];
            if (m_halting) begin
                if (m_elapsed < 1000) m_elapsed++;
            end else if (halt_req) begin
                m_halting = 1'b1; m_elapsed = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        // Reset wins over halt_req and a mispredict in the same cycle.
        set_in(1'b1, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        clear_in(); #1;
        checks++; if (obs !== 5'b00000) $display("FAIL reset_outputs obs=%b exp=%b", obs, 5'b00000); else passes++;
`ifdef HAZARD_STATS_EN
        checks++; if (stall_count !== 32'd0 || flush_count !== 32'd0)
            $display("FAIL reset_counters stall=%0d flush=%0d exp=0/0", stall_count, flush_count); else passes++;
`endif
        tick(); #1;
        checks++; if (obs !== 5'b00000) $display("FAIL reset_no_drain obs=%b exp=%b", obs, 5'b00000); else passes++;
    endtask

    task automatic test_load_use();
        set_in(1'b0, 5'd8, 5'd3, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        checks++; if (obs !== 5'b10100) $display("FAIL lu_rs obs=%b exp=%b", obs, 5'b10100); else passes++;
        tick();
        set_in(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        checks++; if (obs !== 5'b00000) $display("FAIL lu_r0 obs=%b exp=%b", obs, 5'b00000); else passes++;
        tick();
        set_in(1'b0, 5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        checks++; if (obs !== 5'b00000) $display("FAIL lu_rt_unused obs=%b exp=%b", obs, 5'b00000); else passes++;
        tick();
        set_in(1'b0, 5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        checks++; if (obs !== 5'b10100) $display("FAIL lu_rt_used obs=%b exp=%b", obs, 5'b10100); else passes++;
        tick();
        set_in(1'b0, 5'd8, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        checks++; if (obs !== 5'b00000) $display("FAIL lu_no_load obs=%b exp=%b", obs, 5'b00000); else passes++;
        tick();
    endtask

    task automatic test_mispredict();
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); #1;
        checks++; if (obs !== 5'b01110) $display("FAIL mp_taken obs=%b exp=%b", obs, 5'b01110); else passes++;
        tick();
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); #1;
        checks++; if (obs !== 5'b01110) $display("FAIL mp_not_taken obs=%b exp=%b", obs, 5'b01110); else passes++;
        tick();
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0); #1;
        checks++; if (obs !== 5'b00000) $display("FAIL correct_pred obs=%b exp=%b", obs, 5'b00000); else passes++;
        tick();
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
        checks++; if (obs !== 5'b00000) $display("FAIL no_branch obs=%b exp=%b", obs, 5'b00000); else passes++;
        tick();
    endtask

    task automatic test_priority();
        set_in(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); #1;
        checks++; if (obs !== 5'b01110) $display("FAIL mp_over_lu obs=%b exp=%b", obs, 5'b01110); else passes++;
        tick();
    endtask

    task automatic test_drain_halt();
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
        checks++; if (obs !== 5'b00000) $display("FAIL halt_req_cycle obs=%b exp=%b", obs, 5'b00000); else passes++;
        tick();
        for (int i = 0; i < DRAIN; i++) begin
            clear_in();
            if (i == 1) begin
                ex_branch = 1'b1; ex_taken = 1'b0; ex_prediction = 1'b1;
            end
            #1;
            if (i == 1) begin
                checks++; if (obs !== 5'b11110) $display("FAIL drain_mp obs=%b exp=%b", obs, 5'b11110); else passes++;
            end else begin
                checks++; if (obs !== 5'b10100) $display("FAIL drain_%0d obs=%b exp=%b", i, obs, 5'b10100); else passes++;
            end
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            clear_in();
            halt_req = i[0];
            #1;
            checks++; if (obs !== 5'b10101) $display("FAIL halted_%0d obs=%b exp=%b", i, obs, 5'b10101); else passes++;
            tick();
        end
    endtask

    task automatic test_reset_mid_drain();
        set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        clear_in(); halt_req = 1'b1;
        tick();
        clear_in(); #1;
        checks++; if (obs !== 5'b10100) $display("FAIL mdrain_1 obs=%b exp=%b", obs, 5'b10100); else passes++;
        tick();
        clear_in(); reset = 1'b1; #1;
        checks++; if (obs !== 5'b10100) $display("FAIL mdrain_2 obs=%b exp=%b", obs, 5'b10100); else passes++;
        tick();
        clear_in(); #1;
        checks++; if (obs !== 5'b00000) $display("FAIL drain_reset_run obs=%b exp=%b", obs, 5'b00000); else passes++;
        // Same from HALTED.
        halt_req = 1'b1;
        tick();
        clear_in();
        for (int i = 0; i < DRAIN; i++) tick();
        #1;
        checks++; if (obs !== 5'b10101) $display("FAIL reach_halted obs=%b exp=%b", obs, 5'b10101); else passes++;
        reset = 1'b1;
        tick();
        clear_in(); #1;
        checks++; if (obs !== 5'b00000) $display("FAIL halted_reset_run obs=%b exp=%b", obs, 5'b00000); else passes++;
        tick();
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        clear_in(); #1;
        checks++; if (stall_count !== 32'd3) $display("FAIL stats_stall got=%0d exp=3", stall_count); else passes++;
        checks++; if (flush_count !== 32'd2) $display("FAIL stats_flush got=%0d exp=2", flush_count); else passes++;
        set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        clear_in(); #1;
        checks++; if (n_stall_count !== 2'd3) $display("FAIL stats_saturate got=%0d exp=3", n_stall_count); else passes++;
        checks++; if (stall_count !== 32'd5) $display("FAIL stats_wide5 got=%0d exp=5", stall_count); else passes++;
        tick();
    endtask
`endif

    task automatic test_random();
        logic [4:0] e;
        set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 79) == 0),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 39) == 0));
            #1;
            e = model_out();
            checks++; if (obs !== e) $display("FAIL rand_out[%0d] obs=%b exp=%b", i, obs, e); else passes++;
`ifdef HAZARD_STATS_EN
            checks++; if (n_obs !== e) $display("FAIL rand_narrow_out[%0d] obs=%b exp=%b", i, n_obs, e); else passes++;
            checks++; if (stall_count !== 32'(m_stall_tot) || flush_count !== 32'(m_flush_tot))
                $display("FAIL rand_counts[%0d] stall=%0d flush=%0d exp=%0d/%0d", i, stall_count, flush_count,
                         m_stall_tot, m_flush_tot); else passes++;
            checks++; if (n_stall_count !== ((m_stall_tot > 3) ? 2'd3 : 2'(m_stall_tot)) ||
                          n_flush_count !== ((m_flush_tot > 3) ? 2'd3 : 2'(m_flush_tot)))
                $display("FAIL rand_sat_counts[%0d] stall=%0d flush=%0d", i, n_stall_count, n_flush_count); else passes++;
`endif
            tick();
        end
    endtask

    initial begin
        set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_load_use();
        test_mispredict();
        test_priority();
        test_drain_halt();
        test_reset_mid_drain();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter DRAIN_CYCLES, default 4, meaning the number of bubble cycles inserted after halt_req before halted asserts (range 1..15).
REQ-002 Parameter STAT_WIDTH, default 32, meaning the width of the statistics counters.
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port id_rs  input  5  rs field of the instruction in ID.
REQ-006 Port id_rt  input  5  rt field of the instruction in ID.
REQ-007 Port id_uses_rt  input  1  ID instruction reads rt as a source.
REQ-008 Port ie_rt  input  5  rt_out of the ID/IE latch.
REQ-009 Port ie_mem_read  input  1  mem_read_out of the ID/IE latch (load in EX).
REQ-010 Port ex_branch  input  1  branch resolved in EX this cycle.
REQ-011 Port ex_taken  input  1  actual branch outcome in EX.
REQ-012 Port ex_prediction  input  1  branch_prediction_out of the ID/IE latch.
REQ-013 Port halt_req  input  1  request to drain and halt the pipeline.
REQ-014 Port stall  output  1  freezes the PC and the IF/ID latch.
REQ-015 Port flush_if_id  output  1  invalidates the IF/ID latch.
REQ-016 Port flush_id_ie  output  1  drives the ID/IE latch flush input (bubble insert).
REQ-017 Port pc_redirect  output  1  selects the corrected branch PC.
REQ-018 Port halted  output  1  pipeline drained and frozen.
REQ-019 Ports stall_count and flush_count  output  STAT_WIDTH  event counters (present only under REQ-034).

Function
REQ-020 Load-use hazard (LU) SHALL be ie_mem_read && ie_rt!=0 && (ie_rt==id_rs || (id_uses_rt && ie_rt==id_rt)).
REQ-021 Mispredict (MP) SHALL be ex_branch && (ex_taken != ex_prediction).
REQ-022 Hazard outputs SHALL be combinational from current inputs and state (zero-cycle latency).
REQ-023 FSM states SHALL be RUN, DRAIN, HALTED.
REQ-024 In RUN: MP -> flush_if_id=1, flush_id_ie=1, pc_redirect=1, stall=0; else LU -> stall=1, flush_id_ie=1; else all outputs 0.
REQ-025 MP SHALL take priority over LU in the same cycle (dependent instruction is squashed anyway).
REQ-026 RUN -> DRAIN on a clock edge with halt_req=1; drain counter loads DRAIN_CYCLES-1.
REQ-027 In DRAIN: stall=1, flush_id_ie=1 every cycle; counter decrements; at counter==0 next state HALTED.
REQ-028 MP during DRAIN SHALL additionally assert flush_if_id and pc_redirect; the drain count is not restarted.
REQ-029 In HALTED: stall=1, flush_id_ie=1, halted=1; exit only by reset; halt_req ignored.
REQ-030 halted SHALL be 0 in RUN and DRAIN.

Reset
REQ-031 reset SHALL force state RUN, drain counter 0, and statistics counters 0 on the next rising edge.
REQ-032 reset SHALL take priority over every other event, including halt_req and MP in the same cycle; reset mid-DRAIN or in HALTED returns to RUN.
REQ-033 After reset, with no hazard inputs, all outputs SHALL be 0.

Configuration
REQ-034 Macro HAZARD_STATS_EN defined: stall_count increments each cycle stall=1, flush_count increments each cycle flush_if_id=1; both saturate at all-ones.
REQ-035 Macro HAZARD_STATS_EN undefined: the counter ports and logic SHALL be absent; all other behaviour unchanged.

Verification
REQ-036 ie_mem_read=1, ie_rt=8, id_rs=8 in RUN -> stall=1, flush_id_ie=1, flush_if_id=0 that cycle; ie_rt=0 same case -> all outputs 0.
REQ-037 ex_branch=1, ex_taken=1, ex_prediction=0 together with an LU condition -> flush_if_id=1, flush_id_ie=1, pc_redirect=1, stall=0.
REQ-038 halt_req pulsed one cycle, DRAIN_CYCLES=4 -> stall=1 for 4 cycles with halted=0, then halted=1 held indefinitely.
REQ-039 reset asserted in the 2nd DRAIN cycle -> next cycle state RUN, halted=0, stall=0.
REQ-040 HAZARD_STATS_EN defined: 3 LU cycles and 2 MP cycles -> stall_count=3, flush_count=2; STAT_WIDTH=2 with 5 LU cycles -> stall_count=3 (saturated).
